// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the fetch and data ports.
// Serialises accesses, inserts wait states and drives the pipeline stall.
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ifetch_req,
    input  logic [AW-1:0] imemaddr,
    output logic [DW-1:0] imemrdata,
    output logic          ifetch_valid,
    input  logic [AW-1:0] dmemaddr,
    input  logic [DW-1:0] dmemwdata,
    input  logic          dmemread,
    input  logic          dmemwrite,
    output logic [DW-1:0] dmemrdata,
    output logic          dmem_done,
    output logic          stall,
    output logic [AW-2:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_en,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {IDLE, DISSUE, DWAIT, FISSUE, FWAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    wait_q, wait_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [AW-1:0] daddr_q, daddr_d, faddr_q, faddr_d;
    logic          dwe_q, dwe_d;
    logic          dserved_q, dserved_d, fserved_q, fserved_d;
    logic [AW-2:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          en_q, en_d, we_q, we_d;
    logic [DW-1:0] imem_q, imem_d, dmem_q, dmem_d;
    logic          ddone_q, ddone_d, ifv_q, ifv_d;

    logic dpend, fpend, dgo, fgo, last;
    logic dgrant, fgrant, dstore, dcap, fcap, winc;

    // A request already served in this stall episode is not re-issued
    // until the core presents a different address.
    assign dpend  = (dmemread | dmemwrite) &
                    ~(dserved_q & (dmemaddr == daddr_q));
    assign fpend  = ifetch_req & ~(fserved_q & (imemaddr == faddr_q));
    assign dgo    = dpend & ((starve_q < SW'(STARVE_MAX)) | ~fpend);
    assign fgo    = fpend & ~dgo;
    assign last   = (wait_q == 3'(MEM_LAT - 1));

    assign dgrant = (state_q == IDLE) & dgo;
    assign fgrant = (state_q == IDLE) & fgo;
    assign dstore = (state_q == DISSUE) & dwe_q;
    assign dcap   = (state_q == DWAIT) & last;
    assign fcap   = (state_q == FWAIT) & last;
    assign winc   = ((state_q == DWAIT) | (state_q == FWAIT)) & ~last;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            starve_q  <= '0;
            daddr_q   <= '0;
            faddr_q   <= '0;
            dwe_q     <= 1'b0;
            dserved_q <= 1'b0;
            fserved_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            imem_q    <= '0;
            dmem_q    <= '0;
            ddone_q   <= 1'b0;
            ifv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            starve_q  <= starve_d;
            daddr_q   <= daddr_d;
            faddr_q   <= faddr_d;
            dwe_q     <= dwe_d;
            dserved_q <= dserved_d;
            fserved_q <= fserved_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            en_q      <= en_d;
            we_q      <= we_d;
            imem_q    <= imem_d;
            dmem_q    <= dmem_d;
            ddone_q   <= ddone_d;
            ifv_q     <= ifv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (dgo) state_d = DISSUE;
                else if (fgo) state_d = FISSUE;
            end
            DISSUE:  state_d = dwe_q ? DONE : DWAIT;
            DWAIT:   if (last) state_d = DONE;
            FISSUE:  state_d = FWAIT;
            FWAIT:   if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wait_d    = '0;
        starve_d  = starve_q;
        daddr_d   = daddr_q;
        faddr_d   = faddr_q;
        dwe_d     = dwe_q;
        dserved_d = dserved_q;
        fserved_d = fserved_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        en_d      = 1'b0;
        we_d      = 1'b0;
        imem_d    = imem_q;
        dmem_d    = dmem_q;
        ddone_d   = 1'b0;
        ifv_d     = 1'b0;
        unique case (1'b1)
            dgrant: begin
                daddr_d   = dmemaddr;
                dwe_d     = dmemwrite;
                addr_d    = dmemaddr[AW-1:1];
                wdata_d   = dmemwdata;
                en_d      = 1'b1;
                we_d      = dmemwrite;
                dserved_d = 1'b0;
                if (fpend && starve_q < SW'(STARVE_MAX))
                    starve_d = starve_q + 1'b1;
            end
            fgrant: begin
                faddr_d   = imemaddr;
                addr_d    = imemaddr[AW-1:1];
                en_d      = 1'b1;
                fserved_d = 1'b0;
                starve_d  = '0;
            end
            dstore: ddone_d = 1'b1;
            dcap: begin
                dmem_d  = mem_rdata;
                ddone_d = 1'b1;
            end
            fcap: begin
                imem_d = mem_rdata;
                ifv_d  = 1'b1;
            end
            winc:    wait_d = wait_q + 3'd1;
            default: ;
        endcase
        if (!stall) begin
            dserved_d = 1'b0;
            fserved_d = 1'b0;
        end else begin
            if (ddone_q) dserved_d = 1'b1;
            if (ifv_q) fserved_d = 1'b1;
        end
    end

    assign stall        = (dpend & ~ddone_q) | (fpend & ~ifv_q);
    assign imemrdata    = imem_q;
    assign ifetch_valid = ifv_q;
    assign dmemrdata    = dmem_q;
    assign dmem_done    = ddone_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_en       = en_q;
    assign mem_we       = we_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level schedule model plus
// directed scenarios on a MEM_LAT=1 instance and a MEM_LAT=3 instance.
module tb_mem_port_arbiter;
    localparam int SMAX = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- DUT with MEM_LAT=1 ----------------
    logic        reset = 1'b1;
    logic        ifetch_req = 1'b0, dmemread = 1'b0, dmemwrite = 1'b0;
    logic [15:0] imemaddr = '0, dmemaddr = '0, dmemwdata = '0;
    logic [15:0] imemrdata, dmemrdata, mem_wdata, mem_rdata;
    logic        ifetch_valid, dmem_done, stall, mem_en, mem_we;
    logic [14:0] mem_addr;

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1), .STARVE_MAX(SMAX)) u1 (
        .clock(clock), .reset(reset),
        .ifetch_req(ifetch_req), .imemaddr(imemaddr),
        .imemrdata(imemrdata), .ifetch_valid(ifetch_valid),
        .dmemaddr(dmemaddr), .dmemwdata(dmemwdata),
        .dmemread(dmemread), .dmemwrite(dmemwrite),
        .dmemrdata(dmemrdata), .dmem_done(dmem_done), .stall(stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en),
        .mem_we(mem_we), .mem_rdata(mem_rdata));

    // ---------------- DUT with MEM_LAT=3 ----------------
    logic        f3_req = 1'b0, dread3 = 1'b0, dwrite3 = 1'b0;
    logic [15:0] iaddr3 = '0, daddr3 = '0, dwdata3 = '0;
    logic [15:0] irdata3, drdata3, mwdata3, mrdata3;
    logic        ivalid3, ddone3, stall3, men3, mwe3;
    logic [14:0] maddr3;

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(3), .STARVE_MAX(SMAX)) u3 (
        .clock(clock), .reset(reset),
        .ifetch_req(f3_req), .imemaddr(iaddr3),
        .imemrdata(irdata3), .ifetch_valid(ivalid3),
        .dmemaddr(daddr3), .dmemwdata(dwdata3),
        .dmemread(dread3), .dmemwrite(dwrite3),
        .dmemrdata(drdata3), .dmem_done(ddone3), .stall(stall3),
        .mem_addr(maddr3), .mem_wdata(mwdata3), .mem_en(men3),
        .mem_we(mwe3), .mem_rdata(mrdata3));

    // ---------------- memories ----------------
    logic [15:0] mem1 [0:32767];
    logic [15:0] mem3 [0:32767];
    logic [15:0] pd1 [0:3];
    logic [15:0] pd3 [0:3];
    logic [3:0]  pv1 = '0, pv3 = '0;
    logic        pk1 = 1'b0, pk3 = 1'b0;
    logic [14:0] pk_a = '0;
    logic [15:0] pk_d = '0;

    always @(posedge clock) begin
        if (pk1) mem1[pk_a] <= pk_d;
        else if (mem_en && mem_we) mem1[mem_addr] <= mem_wdata;
        for (int i = 3; i > 0; i--) begin
            pd1[i] <= pd1[i-1];
            pv1[i] <= pv1[i-1];
        end
        pd1[0] <= mem1[mem_addr];
        pv1[0] <= mem_en && !mem_we;
    end

    always @(posedge clock) begin
        if (pk3) mem3[pk_a] <= pk_d;
        else if (men3 && mwe3) mem3[maddr3] <= mwdata3;
        for (int i = 3; i > 0; i--) begin
            pd3[i] <= pd3[i-1];
            pv3[i] <= pv3[i-1];
        end
        pd3[0] <= mem3[maddr3];
        pv3[0] <= men3 && !mwe3;
    end

    // Read data is only meaningful in the cycle it is due; poison otherwise.
    assign mem_rdata = pv1[0] ? pd1[0] : 16'hDEAD;
    assign mrdata3   = pv3[2] ? pd3[2] : 16'hDEAD;

    // ---------------- schedule model for u1 ----------------
    int          P = -1, E = -1, freec = 0, starve = 0;
    bit          kd, pwe, dsv, fsv;
    logic [15:0] paddr, pwd, pdata, dsa, fsa;
    logic [15:0] e_ird = '0, e_drd = '0;
    logic [14:0] en_q[$];
    int          en_cyc, v_cyc, d_cyc, stall_hi, v_cnt = 0;
    bit          we_last;

    always @(negedge clock) begin
        bit dp, fp, xd, xv, xs, xe;
        if (reset) begin
            P = -1; E = -1; freec = cyc + 1; starve = 0;
            e_ird = '0; e_drd = '0; dsv = 0; fsv = 0;
        end else begin
            dp = (dmemread || dmemwrite) && !(dsv && dmemaddr == dsa);
            fp = ifetch_req && !(fsv && imemaddr == fsa);
            xd = (cyc == P) && kd;
            xv = (cyc == P) && !kd;
            if (xd && !pwe) e_drd = pdata;
            if (xv) e_ird = pdata;
            xs = (dp && !xd) || (fp && !xv);
            xe = (cyc == E);
            chk("stall", stall, xs);
            chk("mem_en", mem_en, xe);
            chk("mem_we", mem_we, xe && pwe);
            if (xe) chk("mem_addr", mem_addr, paddr[15:1]);
            if (xe && pwe) chk("mem_wdata", mem_wdata, pwd);
            chk("ifetch_valid", ifetch_valid, xv);
            chk("dmem_done", dmem_done, xd);
            chk("imemrdata", imemrdata, e_ird);
            chk("dmemrdata", dmemrdata, e_drd);
            if (!xs) begin
                dsv = 0; fsv = 0;
            end else begin
                if (xd) begin dsv = 1; dsa = paddr; end
                if (xv) begin fsv = 1; fsa = paddr; end
            end
            if (cyc >= freec) begin
                if (dp && (starve < SMAX || !fp)) begin
                    kd = 1; pwe = dmemwrite; paddr = dmemaddr;
                    pwd = dmemwdata; pdata = mem1[dmemaddr[15:1]];
                    E = cyc + 1; P = pwe ? cyc + 2 : cyc + 3;
                    freec = P + 1; dsv = 0;
                    if (fp && starve < SMAX) starve++;
                end else if (fp) begin
                    kd = 0; pwe = 0; paddr = imemaddr;
                    pdata = mem1[imemaddr[15:1]];
                    E = cyc + 1; P = cyc + 3;
                    freec = P + 1; fsv = 0; starve = 0;
                end
            end
        end
        if (mem_en) begin
            en_q.push_back(mem_addr); en_cyc = cyc; we_last = mem_we;
        end
        if (ifetch_valid) begin v_cyc = cyc; v_cnt++; end
        if (dmem_done) d_cyc = cyc;
        if (stall) stall_hi = cyc;
    end

    int d3_cyc, d3_cnt = 0;
    always @(negedge clock)
        if (ddone3) begin d3_cyc = cyc; d3_cnt++; end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic poke(input bit which3, input logic [14:0] a,
                        input logic [15:0] d);
        pk_a = a; pk_d = d;
        if (which3) pk3 = 1'b1; else pk1 = 1'b1;
        tick();
        pk1 = 1'b0; pk3 = 1'b0;
    endtask

    task automatic drop1();
        ifetch_req = 0; dmemread = 0; dmemwrite = 0;
    endtask

    task automatic go_idle(input string nm);
        int n = 0;
        @(negedge clock);
        while (stall && n < 80) begin
            @(negedge clock);
            n++;
        end
        if (stall) chk({nm, "_timeout"}, 1, 0);
        tick();
        drop1();
    endtask

    task automatic go_idle3(input string nm);
        int n = 0;
        @(negedge clock);
        while (stall3 && n < 80) begin
            @(negedge clock);
            n++;
        end
        if (stall3) chk({nm, "_timeout"}, 1, 0);
        tick();
        dread3 = 0; dwrite3 = 0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        @(negedge clock);
        while (!dmem_done && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!dmem_done) chk({nm, "_timeout"}, 1, 0);
    endtask

    int T, vc;

    initial begin
        reset = 1'b1;
        poke(0, 15'd2, 16'h2481);
        poke(0, 15'h08, 16'h1111);
        poke(0, 15'h10, 16'h2222);
        poke(0, 15'h20, 16'h3333);
        for (int i = 0; i < 5; i++)
            poke(0, 15'(16'h80 + i), 16'hA000 + 16'(i));
        poke(1, 15'd5, 16'h5A5A);
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_stall", stall, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_imemrdata", imemrdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        tick();

        // single fetch at 0x0004
        tick();
        ifetch_req = 1; imemaddr = 16'h0004; T = cyc;
        en_q.delete();
        go_idle("t2");
        chk("t2_en_cyc", en_cyc, T + 1);
        chk("t2_en_addr", en_q[0], 15'd2);
        chk("t2_valid_cyc", v_cyc, T + 3);
        chk("t2_imemrdata", imemrdata, 16'h2481);
        chk("t2_stall_last", stall_hi, T + 2);

        // fetch and load together: data first
        tick();
        ifetch_req = 1; imemaddr = 16'h0010;
        dmemread = 1; dmemaddr = 16'h0020; T = cyc;
        en_q.delete();
        go_idle("t3");
        chk("t3_n_access", en_q.size(), 2);
        chk("t3_first_addr", en_q[0], 15'h10);
        chk("t3_second_addr", en_q[1], 15'h08);
        chk("t3_done_cyc", d_cyc, T + 3);
        chk("t3_valid_cyc", v_cyc, T + 7);
        chk("t3_stall_last", stall_hi, T + 6);
        chk("t3_dmemrdata", dmemrdata, 16'h2222);
        chk("t3_imemrdata", imemrdata, 16'h1111);

        // store with read and write both set
        tick();
        dmemread = 1; dmemwrite = 1; dmemaddr = 16'h0006;
        dmemwdata = 16'hBEEF; T = cyc;
        en_q.delete();
        go_idle("t4s");
        chk("t4_we", we_last, 1);
        chk("t4_addr", en_q[0], 15'd3);
        chk("t4_done_cyc", d_cyc, T + 2);
        chk("t4_rdata_held", dmemrdata, 16'h2222);
        tick();
        dmemread = 1; dmemaddr = 16'h0006;
        go_idle("t4l");
        chk("t4_load", dmemrdata, 16'hBEEF);

        // reset held 3 cycles during the fetch wait state
        tick();
        ifetch_req = 1; imemaddr = 16'h0010; T = cyc;
        vc = v_cnt;
        tick();
        tick();
        reset = 1; drop1();
        @(negedge clock);
        tick();
        chk("t1_in_rst_en", mem_en, 0);
        tick();
        tick();
        reset = 0;
        @(negedge clock);
        chk("t1_stall", stall, 0);
        chk("t1_mem_en", mem_en, 0);
        chk("t1_imemrdata", imemrdata, 0);
        chk("t1_dmemrdata", dmemrdata, 0);
        tick();
        tick();
        tick();
        chk("t1_no_valid", v_cnt, vc);

        // starvation: fetch pending while loads keep arriving
        tick();
        ifetch_req = 1; imemaddr = 16'h0040;
        dmemread = 1; dmemaddr = 16'h0100;
        en_q.delete();
        for (int k = 0; k < 4; k++) begin
            wait_done("t6");
            tick();
            dmemaddr = 16'h0100 + 16'(2 * (k + 1));
        end
        go_idle("t6");
        chk("t6_n_access", en_q.size(), 6);
        for (int k = 0; k < 4; k++)
            chk("t6_data_addr", en_q[k], 15'(16'h80 + k));
        chk("t6_fetch_addr", en_q[4], 15'h20);
        chk("t6_data5_addr", en_q[5], 15'h84);
        chk("t6_imemrdata", imemrdata, 16'h3333);
        chk("t6_dmemrdata", dmemrdata, 16'hA004);

        // MEM_LAT=3 instance
        tick();
        dread3 = 1; daddr3 = 16'h000A; T = cyc;
        go_idle3("t5a");
        chk("t5_done_cyc", d3_cyc, T + 5);
        chk("t5_pulses", d3_cnt, 1);
        chk("t5_rdata", drdata3, 16'h5A5A);
        tick();
        dwrite3 = 1; daddr3 = 16'h000A; dwdata3 = 16'h1234; T = cyc;
        go_idle3("t5b");
        chk("t5_store_cyc", d3_cyc, T + 2);
        chk("t5_held", drdata3, 16'h5A5A);
        tick();
        dread3 = 1; T = cyc;
        go_idle3("t5c");
        chk("t5_reload_cyc", d3_cyc, T + 5);
        chk("t5_reload", drdata3, 16'h1234);
        chk("t5_pulses3", d3_cnt, 3);

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
